// File: rtl/reset_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reset_sequencer                                                          |
// | Merges a synchronised async reset request and a software reset pulse,    |
// | then releases NUM_CH reset outputs one by one after a hold period.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int STEP_CYCLES = 8
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              async_rst_i,
  input  logic              sw_rst_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic              done_o,
  output logic [1:0]        state_o
);

  localparam int c_MAX_CNT = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
  localparam int c_CNT_W   = $clog2(c_MAX_CNT + 1);
  localparam int c_IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_STEP_LAST = c_CNT_W'(STEP_CYCLES - 1);
  localparam logic [c_IDX_W-1:0] c_LAST_CH   = c_IDX_W'(NUM_CH - 1);

  localparam logic [1:0] c_ST_ASSERT  = 2'd0;
  localparam logic [1:0] c_ST_HOLD    = 2'd1;
  localparam logic [1:0] c_ST_RELEASE = 2'd2;
  localparam logic [1:0] c_ST_DONE    = 2'd3;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [NUM_CH-1:0]      r_rst;
  logic                   r_done;
  logic [c_CNT_W-1:0]     r_cnt;
  logic [c_IDX_W-1:0]     r_idx;
  logic                   w_req;
  logic [NUM_CH-1:0]      w_clear;

  // Sync chain powers up asserted so a reset request is presumed until proven quiet.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_rst_i};
    end
  end

  assign w_req = r_sync[SYNC_STAGES-1] | sw_rst_i;

  always_comb begin
    w_clear = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_clear[k] = (r_idx == c_IDX_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i || w_req) begin
      r_state <= c_ST_ASSERT;
      r_rst   <= '1;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        c_ST_ASSERT: begin
          r_state <= c_ST_HOLD;
          r_cnt   <= '0;
        end
        c_ST_HOLD: begin
          if (r_cnt == c_HOLD_LAST) begin
            r_rst <= r_rst & ~w_clear;
            r_cnt <= '0;
            if (NUM_CH == 1) begin
              r_state <= c_ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= c_ST_RELEASE;
              r_idx   <= r_idx + c_IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_ST_RELEASE: begin
          if (r_cnt == c_STEP_LAST) begin
            r_rst <= r_rst & ~w_clear;
            r_cnt <= '0;
            if (r_idx == c_LAST_CH) begin
              r_state <= c_ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + c_IDX_W'(1);
            end
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        c_ST_DONE: begin
          r_state <= c_ST_DONE;
        end
        default: begin
          r_state <= c_ST_ASSERT;
        end
      endcase
    end
  end

  assign rst_o   = r_rst;
  assign done_o  = r_done;
  assign state_o = r_state;

endmodule
`default_nettype wire
